// File: rtl/serial_to_vector_n_pkg.sv
// Shared types and helpers for serial_to_vector_n.
// Holds the per-cycle action decode enum and the fill-count width helper.
// No logic lives here; the package is imported by the top module.
package serial_to_vector_n_pkg;

  // One action per cycle, already resolved by priority (clear > sof > next).
  typedef enum logic [1:0] {
    ACT_IDLE  = 2'd0,
    ACT_CLEAR = 2'd1,
    ACT_SOF   = 2'd2,
    ACT_NEXT  = 2'd3
  } act_e;

  // Fill-count width: a single-lane frame still needs a 1-bit counter port.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_to_vector_n.sv
// Purpose: gathers NUM_INPUTS serial samples into one packed vector (lane 0 = first sample).
// Latency: o_dat_valid pulses the cycle after the sample that fills the last lane.
// Backpressure: none; every i_valid sample is taken, full-rate back-to-back frames supported.
//
// Ports:
//   clk, rst      rising-edge clock; asynchronous active-low reset (0 = reset)
//   i_dat         serial sample, accepted when i_valid
//   i_valid       sample strobe; with it low nothing changes
//   i_sof         with i_valid: sample starts a new frame in lane 0
//   i_clear       synchronous abort of the partial frame, overrides any same-cycle sample
//   o_dat_vector  last complete frame, lane k at [k*DWIDTH +: DWIDTH]
//   o_dat_valid   one-cycle pulse when o_dat_vector has just been updated
//   o_fill        number of samples held in the current partial frame
//   o_drop        one-cycle pulse when i_sof discarded a non-empty partial frame
module serial_to_vector_n
  import serial_to_vector_n_pkg::*;
#(
  parameter  int NUM_INPUTS = 16,
  parameter  int DWIDTH     = 8,
  localparam int CNTW       = cnt_width(NUM_INPUTS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DWIDTH-1:0]            i_dat,
  input  logic                         i_valid,
  input  logic                         i_sof,
  input  logic                         i_clear,
  output logic [NUM_INPUTS*DWIDTH-1:0] o_dat_vector,
  output logic                         o_dat_valid,
  output logic [CNTW-1:0]              o_fill,
  output logic                         o_drop
);

  localparam logic [CNTW-1:0] LAST_LANE = CNTW'(NUM_INPUTS - 1);

  logic [CNTW-1:0]              cnt;
  logic [NUM_INPUTS*DWIDTH-1:0] stage;
  logic [NUM_INPUTS*DWIDTH-1:0] stage_nxt;
  logic [CNTW-1:0]              wr_lane;
  logic                         accept;
  logic                         done;
  act_e                         act;

  // Priority decode of the cycle's action.
  always_comb begin
    act = ACT_IDLE;
    if (i_clear) begin
      act = ACT_CLEAR;
    end else if (i_valid) begin
      act = i_sof ? ACT_SOF : ACT_NEXT;
    end
  end

  assign accept  = (act == ACT_SOF) || (act == ACT_NEXT);
  assign wr_lane = (act == ACT_SOF) ? '0 : cnt;
  // With NUM_INPUTS==1 the last lane is lane 0, so every accepted sample completes.
  assign done    = accept && (wr_lane == LAST_LANE);

  // Staging contents including this cycle's sample, so a completing frame can be
  // copied out in the same edge that writes its final lane.
  always_comb begin
    stage_nxt = stage;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (wr_lane == CNTW'(k)) begin
        stage_nxt[k*DWIDTH +: DWIDTH] = i_dat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      stage        <= '0;
      o_dat_vector <= '0;
      o_dat_valid  <= 1'b0;
      o_drop       <= 1'b0;
    end else begin
      o_dat_valid <= 1'b0;
      o_drop      <= 1'b0;
      unique case (act)
        ACT_CLEAR: begin
          cnt <= '0;
        end
        ACT_SOF, ACT_NEXT: begin
          stage  <= stage_nxt;
          o_drop <= (act == ACT_SOF) && (cnt != '0);
          if (done) begin
            cnt          <= '0;
            o_dat_vector <= stage_nxt;
            o_dat_valid  <= 1'b1;
          end else begin
            cnt <= wr_lane + CNTW'(1);
          end
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

  assign o_fill = cnt;

endmodule

// File: tb/tb_serial_to_vector_n.sv
// Bench for serial_to_vector_n: a 4-lane instance carries the main tests and a
// 1-lane instance covers the degenerate frame size. Expected vectors are queued
// when the last sample is driven and popped when o_dat_valid is seen.
module tb_serial_to_vector_n;

  logic        clk;
  logic        rst;

  // 4-lane instance
  logic [7:0]  i_dat;
  logic        i_valid, i_sof, i_clear;
  logic [31:0] o_dat_vector;
  logic        o_dat_valid, o_drop;
  logic [1:0]  o_fill;

  // 1-lane instance
  logic [7:0]  d1_dat;
  logic        d1_valid, d1_sof, d1_clear;
  logic [7:0]  d1_vector;
  logic        d1_dat_valid, d1_drop;
  logic [0:0]  d1_fill;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  exp1_q[$];

  serial_to_vector_n #(.NUM_INPUTS(4), .DWIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .i_dat(i_dat), .i_valid(i_valid), .i_sof(i_sof),
    .i_clear(i_clear), .o_dat_vector(o_dat_vector), .o_dat_valid(o_dat_valid),
    .o_fill(o_fill), .o_drop(o_drop)
  );

  serial_to_vector_n #(.NUM_INPUTS(1), .DWIDTH(8)) u_dut1 (
    .clk(clk), .rst(rst), .i_dat(d1_dat), .i_valid(d1_valid), .i_sof(d1_sof),
    .i_clear(d1_clear), .o_dat_vector(d1_vector), .o_dat_valid(d1_dat_valid),
    .o_fill(d1_fill), .o_drop(d1_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every completed frame must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && o_dat_valid) begin
      if (exp_q.size() == 0) chk("unexpected_vld", 64'(o_dat_vector), 64'hDEAD);
      else                   chk("vector", 64'(o_dat_vector), 64'(exp_q.pop_front()));
    end
    if (rst && d1_dat_valid) begin
      if (exp1_q.size() == 0) chk("n1_unexpected_vld", 64'(d1_vector), 64'hDEAD);
      else                    chk("n1_vector", 64'(d1_vector), 64'(exp1_q.pop_front()));
    end
  end

  // One clock of stimulus on the 4-lane instance; returns 1 time unit after the edge.
  task automatic cyc(input logic v, input logic s, input logic c, input logic [7:0] d);
    i_valid = v; i_sof = s; i_clear = c; i_dat = d;
    @(posedge clk); #1;
    i_valid = 1'b0; i_sof = 1'b0; i_clear = 1'b0;
  endtask

  task automatic cyc1(input logic v, input logic s, input logic [7:0] d);
    d1_valid = v; d1_sof = s; d1_dat = d;
    @(posedge clk); #1;
    d1_valid = 1'b0; d1_sof = 1'b0;
  endtask

  initial begin
    logic [7:0] t1 [4];
    logic [7:0] t6 [4];
    int         sum;
    t1 = '{8'h11, 8'h22, 8'h33, 8'h44};
    t6 = '{8'd10, 8'd20, 8'd30, 8'd40};

    i_dat = '0; i_valid = 0; i_sof = 0; i_clear = 0;
    d1_dat = '0; d1_valid = 0; d1_sof = 0; d1_clear = 0;
    rst = 1'b1;
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vector", 64'(o_dat_vector), 64'h0);
    chk("rst_valid",  64'(o_dat_valid), 64'h0);
    chk("rst_fill",   64'(o_fill), 64'h0);
    chk("rst_drop",   64'(o_drop), 64'h0);
    rst = 1'b1;

    // 1: single frame, fill count walks 1,2,3,0
    exp_q.push_back(32'h44332211);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, t1[i]);
      chk("t1_fill", 64'(o_fill), 64'((i + 1) % 4));
      chk("t1_vld",  64'(o_dat_valid), 64'(i == 3));
    end
    cyc(0, 0, 0, 8'h00);
    chk("t1_vld_pulse", 64'(o_dat_valid), 64'h0);
    chk("t1_hold",      64'(o_dat_vector), 64'h44332211);

    // 2: three back-to-back frames at full rate
    exp_q.push_back(32'h04030201);
    exp_q.push_back(32'h08070605);
    exp_q.push_back(32'h0C0B0A09);
    for (int i = 0; i < 12; i++) begin
      cyc(1, 0, 0, 8'(i + 1));
      chk("t2_vld", 64'(o_dat_valid), 64'(i % 4 == 3));
    end

    // 3: sof mid-frame drops A,B and restarts at C
    cyc(1, 0, 0, 8'hAA);
    cyc(1, 0, 0, 8'hBB);
    chk("t3_fill2", 64'(o_fill), 64'd2);
    cyc(1, 1, 0, 8'hC0);
    chk("t3_drop", 64'(o_drop), 64'h1);
    chk("t3_fill_sof", 64'(o_fill), 64'd1);
    cyc(1, 0, 0, 8'hD0);
    chk("t3_drop_pulse", 64'(o_drop), 64'h0);
    exp_q.push_back(32'hF0E0D0C0);
    cyc(1, 0, 0, 8'hE0);
    cyc(1, 0, 0, 8'hF0);
    chk("t3_vld", 64'(o_dat_valid), 64'h1);

    // 4: clear wins over a same-cycle 4th sample
    cyc(1, 0, 0, 8'h01);
    cyc(1, 0, 0, 8'h02);
    cyc(1, 0, 0, 8'h03);
    cyc(1, 0, 1, 8'h04);
    chk("t4_fill", 64'(o_fill), 64'h0);
    chk("t4_vld",  64'(o_dat_valid), 64'h0);
    chk("t4_drop", 64'(o_drop), 64'h0);
    cyc(1, 1, 0, 8'h41);
    chk("t4_sof_empty_nodrop", 64'(o_drop), 64'h0);
    exp_q.push_back(32'h44434241);
    cyc(1, 0, 0, 8'h42);
    cyc(1, 0, 0, 8'h43);
    cyc(1, 0, 0, 8'h44);

    // 5: gapped input, async reset mid-frame
    cyc(1, 0, 0, 8'h51);
    cyc(0, 1, 0, 8'hEE);
    chk("t5_idle_fill", 64'(o_fill), 64'd1);
    chk("t5_idle_drop", 64'(o_drop), 64'h0);
    cyc(0, 0, 0, 8'hEE);
    cyc(1, 0, 0, 8'h52);
    chk("t5_fill2", 64'(o_fill), 64'd2);
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_vector", 64'(o_dat_vector), 64'h0);
    chk("t5_rst_fill",   64'(o_fill), 64'h0);
    chk("t5_rst_valid",  64'(o_dat_valid), 64'h0);
    chk("t5_rst_drop",   64'(o_drop), 64'h0);
    #1 rst = 1'b1;
    exp_q.push_back(32'h64636261);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 8'(8'h61 + i));
      chk("t5_fill", 64'(o_fill), 64'((i + 1) % 4));
      cyc(0, 0, 0, 8'h00);
      chk("t5_gap_vld", 64'(o_dat_valid), 64'h0);
      cyc(0, 0, 0, 8'h00);
    end

    // 6: lane sanity for a downstream averager: 10,20,30,40 -> 25
    exp_q.push_back(32'h281E140A);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, t6[i]);
    sum = 0;
    for (int k = 0; k < 4; k++) sum += int'(o_dat_vector[k*8 +: 8]);
    chk("t6_avg", 64'(sum / 4), 64'd25);

    // 6: single-lane instance completes on every sample, sof never drops
    for (int i = 0; i < 4; i++) begin
      exp1_q.push_back(8'(8'h10 * (i + 1)));
      cyc1(1, (i == 2), 8'(8'h10 * (i + 1)));
      chk("n1_vld",  64'(d1_dat_valid), 64'h1);
      chk("n1_fill", 64'(d1_fill), 64'h0);
      chk("n1_drop", 64'(d1_drop), 64'h0);
    end
    cyc1(0, 0, 8'h00);
    chk("n1_vld_pulse", 64'(d1_dat_valid), 64'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("q_empty",  64'(exp_q.size()), 64'h0);
    chk("q1_empty", 64'(exp1_q.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
